// File: rtl/chn_arb_rr.sv
// chn_arb_rr: round-robin arbiter for the PCIe endpoint TX interface.
// One-hot grant (trn) held until the winner starts driving (drvn), then the
// arbiter waits for release and inserts one turnaround cycle before
// re-arbitrating. All outputs are registered.
//
// Optional build macro: CHN_ARB_GNT_TIMEOUT_EN
//   defined   -> a grant not acknowledged within TIMEOUT_CYC GNT cycles is
//                revoked and gnt_to pulses for one cycle.
//   undefined -> GNT waits indefinitely; gnt_to is tied low.
module chn_arb_rr #(
    parameter int NUM_CHN     = 4,
    parameter int CHN_W       = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CHN-1:0] reqep,
    input  logic [NUM_CHN-1:0] drvn,
    output logic [NUM_CHN-1:0] trn,
    output logic [CHN_W-1:0]   grant_id,
    output logic               grant_vld,
    output logic               err_drv,
    output logic               gnt_to
);

    typedef enum logic [2:0] {
        S_INIT,
        S_ARB,
        S_GNT,
        S_BUSY,
        S_GAP
    } state_t;

    // Reject parameter sets the arbiter cannot represent.
    if (NUM_CHN < 1 || NUM_CHN > 16 || CHN_W < 1 || (1 << CHN_W) < NUM_CHN ||
        TIMEOUT_CYC < 2) begin : g_param_chk
        $error("chn_arb_rr: illegal parameter combination");
    end

    state_t             state, state_nxt;
    logic [NUM_CHN-1:0] trn_nxt;
    logic [CHN_W-1:0]   id_nxt;
    logic               vld_nxt;
    logic               err_nxt;
    // One-hot copy of the current owner; survives trn dropping in BUSY.
    logic [NUM_CHN-1:0] own, own_nxt;
    logic [CHN_W-1:0]   ptr, ptr_nxt;

    logic [CHN_W-1:0]   win_id;
    logic [NUM_CHN-1:0] win_oh;
    logic               drv_own;
    logic               req_own;
    logic               drv_other;

    assign drv_own   = |(drvn & own);
    assign req_own   = |(reqep & own);
    assign drv_other = |(drvn & ~own);

`ifdef CHN_ARB_GNT_TIMEOUT_EN
    // Counter holds TIMEOUT_CYC-1 at most, so log2 bits suffice.
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             tmo_hit;
    logic             gnt_to_nxt;

    assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign gnt_to = 1'b0;
`endif

    // Winner search: lowest requester above ptr, else wrap to lowest at/below ptr.
    always_comb begin
        win_id = '0;
        win_oh = '0;
        // Wrap-around candidates first; the above-ptr pass then overrides them.
        for (int i = NUM_CHN - 1; i >= 0; i--) begin
            if (reqep[i] && i <= int'(ptr)) win_id = CHN_W'(i);
        end
        for (int i = NUM_CHN - 1; i >= 0; i--) begin
            if (reqep[i] && i > int'(ptr)) win_id = CHN_W'(i);
        end
        for (int i = 0; i < NUM_CHN; i++) begin
            win_oh[i] = (win_id == CHN_W'(i));
        end
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        trn_nxt   = trn;
        id_nxt    = grant_id;
        vld_nxt   = grant_vld;
        own_nxt   = own;
        ptr_nxt   = ptr;
        err_nxt   = err_drv;
`ifdef CHN_ARB_GNT_TIMEOUT_EN
        cnt_nxt    = '0;
        gnt_to_nxt = 1'b0;
`endif
        case (state)
            S_INIT: begin
                trn_nxt   = '0;
                state_nxt = S_ARB;
            end
            S_ARB: begin
                // A channel still driving from a previous owner blocks any new grant.
                if (!(|drvn) && (|reqep)) begin
                    trn_nxt   = win_oh;
                    own_nxt   = win_oh;
                    id_nxt    = win_id;
                    vld_nxt   = 1'b1;
                    ptr_nxt   = win_id;
                    state_nxt = S_GNT;
                end
            end
            S_GNT: begin
                if (drv_own) begin
                    trn_nxt   = '0;
                    state_nxt = S_BUSY;
                end else if (!req_own) begin
                    // Withdrawn request: the channel forfeits its turn (ptr kept).
                    trn_nxt   = '0;
                    vld_nxt   = 1'b0;
                    state_nxt = S_GAP;
`ifdef CHN_ARB_GNT_TIMEOUT_EN
                end else if (tmo_hit) begin
                    trn_nxt    = '0;
                    vld_nxt    = 1'b0;
                    gnt_to_nxt = 1'b1;
                    state_nxt  = S_GAP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
`endif
                end
            end
            S_BUSY: begin
                trn_nxt = '0;
                vld_nxt = 1'b1;
                if (!drv_own) begin
                    vld_nxt   = 1'b0;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                state_nxt = S_ARB;
            end
            default: begin
                trn_nxt   = '0;
                vld_nxt   = 1'b0;
                state_nxt = S_INIT;
            end
        endcase
        // A non-owner driving while a grant is live is flagged until reset.
        if ((state == S_GNT || state == S_BUSY) && drv_other) begin
            err_nxt = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) begin
            state     <= S_INIT;
            trn       <= '0;
            grant_id  <= '0;
            grant_vld <= 1'b0;
            err_drv   <= 1'b0;
            own       <= '0;
            ptr       <= CHN_W'(NUM_CHN - 1);
        end else begin
            state     <= state_nxt;
            trn       <= trn_nxt;
            grant_id  <= id_nxt;
            grant_vld <= vld_nxt;
            err_drv   <= err_nxt;
            own       <= own_nxt;
            ptr       <= ptr_nxt;
        end
    end

`ifdef CHN_ARB_GNT_TIMEOUT_EN
    // Grant-acknowledge timeout counter and its one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            gnt_to <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            gnt_to <= gnt_to_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_chn_arb_rr.sv
// Testbench for chn_arb_rr (NUM_CHN=4) plus a NUM_CHN=1 instance.
// Table of per-cycle {inputs, expected outputs} rows, then hand-written
// sequences for the grant-hold / timeout corner and the single-channel case.
module tb_chn_arb_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] reqep, drvn, trn;
    logic [1:0] grant_id;
    logic       grant_vld, err_drv, gnt_to;

    logic       req1, drv1, trn1, id1, vld1, err1, to1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    chn_arb_rr #(.NUM_CHN(4), .CHN_W(2), .TIMEOUT_CYC(8)) u_dut (
        .clk(clk), .rst(rst), .reqep(reqep), .drvn(drvn), .trn(trn),
        .grant_id(grant_id), .grant_vld(grant_vld), .err_drv(err_drv), .gnt_to(gnt_to)
    );

    chn_arb_rr #(.NUM_CHN(1), .CHN_W(1), .TIMEOUT_CYC(8)) u_one (
        .clk(clk), .rst(rst), .reqep(req1), .drvn(drv1), .trn(trn1),
        .grant_id(id1), .grant_vld(vld1), .err_drv(err1), .gnt_to(to1)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] drv;
        logic [3:0] trn;
        logic [1:0] id;
        logic       vld;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] dv,
                                input logic [3:0] t, input logic [1:0] id,
                                input logic v, input logic e);
        vec_t x;
        x.rst = r; x.req = rq; x.drv = dv; x.trn = t; x.id = id; x.vld = v; x.err = e;
        tbl.push_back(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs already set, sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; reqep = '0; drvn = '0; req1 = 1'b0; drv1 = 1'b0;

        // ---- Round robin, all requesting, 3-cycle drive: grants 0,1,2,3,0 ----
        add(0, 4'hF, 4'h0, 4'h0, 2'd0, 0, 0);               // INIT -> ARB
        for (int g = 0; g < 5; g++) begin
            logic [1:0] c;
            logic [3:0] oh;
            c  = 2'(g % 4);
            oh = 4'b0001 << c;
            add(0, 4'hF, 4'h0, oh,   c, 1, 0);              // ARB -> GNT
            add(0, 4'hF, oh,   4'h0, c, 1, 0);              // GNT -> BUSY
            add(0, 4'hF, oh,   4'h0, c, 1, 0);
            add(0, 4'hF, oh,   4'h0, c, 1, 0);
            add(0, 4'hF, 4'h0, 4'h0, c, 0, 0);              // BUSY -> GAP
            add(0, 4'hF, 4'h0, 4'h0, c, 0, 0);              // GAP -> ARB
        end
        // ---- Channel 2 alone, pulsed; drvn beats withdrawn reqep in GNT ----
        for (int r = 0; r < 2; r++) begin
            add(0, 4'h4, 4'h0, 4'h4, 2'd2, 1, 0);
            add(0, 4'h0, 4'h4, 4'h0, 2'd2, 1, 0);
            add(0, 4'h0, 4'h4, 4'h0, 2'd2, 1, 0);
            add(0, 4'h0, 4'h0, 4'h0, 2'd2, 0, 0);
            add(0, 4'h0, 4'h0, 4'h0, 2'd2, 0, 0);
            add(0, 4'h0, 4'h0, 4'h0, 2'd2, 0, 0);            // idle in ARB
        end
        // ---- Abort: ch1 granted, drops request, ch2 next ----
        add(0, 4'h6, 4'h0, 4'h2, 2'd1, 1, 0);
        add(0, 4'h4, 4'h0, 4'h0, 2'd1, 0, 0);               // GNT -> GAP
        add(0, 4'h4, 4'h0, 4'h0, 2'd1, 0, 0);               // GAP -> ARB
        add(0, 4'h4, 4'h0, 4'h4, 2'd2, 1, 0);
        add(0, 4'h0, 4'h4, 4'h0, 2'd2, 1, 0);
        add(0, 4'h0, 4'h0, 4'h0, 2'd2, 0, 0);
        add(0, 4'h0, 4'h0, 4'h0, 2'd2, 0, 0);
        // ---- Foreign driver during BUSY on ch0 -> sticky err_drv ----
        add(0, 4'h1, 4'h0, 4'h1, 2'd0, 1, 0);
        add(0, 4'h0, 4'h1, 4'h0, 2'd0, 1, 0);
        add(0, 4'h0, 4'h9, 4'h0, 2'd0, 1, 1);
        add(0, 4'h0, 4'h1, 4'h0, 2'd0, 1, 1);
        add(0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 1);
        add(0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 1);
        // ---- rst clears err_drv; rst while BUSY on ch2; ch0 wins afterwards ----
        add(1, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0);
        add(0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0);
        add(0, 4'h4, 4'h0, 4'h4, 2'd2, 1, 0);
        add(0, 4'h4, 4'h4, 4'h0, 2'd2, 1, 0);
        add(1, 4'h0, 4'h4, 4'h0, 2'd0, 0, 0);               // reset mid-BUSY
        add(0, 4'h0, 4'h4, 4'h0, 2'd0, 0, 0);               // INIT -> ARB
        add(0, 4'h5, 4'h4, 4'h0, 2'd0, 0, 0);               // stale driver blocks
        add(0, 4'h5, 4'h0, 4'h1, 2'd0, 1, 0);               // ch0 first
        add(0, 4'h4, 4'h1, 4'h0, 2'd0, 1, 0);
        add(0, 4'h4, 4'h0, 4'h0, 2'd0, 0, 0);
        add(0, 4'h4, 4'h0, 4'h0, 2'd0, 0, 0);
        add(0, 4'h4, 4'h0, 4'h4, 2'd2, 1, 0);
        add(0, 4'h0, 4'h0, 4'h0, 2'd2, 0, 0);               // abort
        add(0, 4'h0, 4'h0, 4'h0, 2'd2, 0, 0);               // back to ARB

        // ---- Reset state ----
        step();
        step();
        check("reset trn", 32'(trn), 32'h0);
        check("reset grant_id", 32'(grant_id), 32'h0);
        check("reset grant_vld", 32'(grant_vld), 32'h0);
        check("reset err_drv", 32'(err_drv), 32'h0);
        check("reset gnt_to", 32'(gnt_to), 32'h0);

        // ---- Table ----
        for (int i = 0; i < tbl.size(); i++) begin
            rst   = tbl[i].rst;
            reqep = tbl[i].req;
            drvn  = tbl[i].drv;
            step();
            check($sformatf("row%0d trn", i), 32'(trn), 32'(tbl[i].trn));
            check($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(tbl[i].id));
            check($sformatf("row%0d grant_vld", i), 32'(grant_vld), 32'(tbl[i].vld));
            check($sformatf("row%0d err_drv", i), 32'(err_drv), 32'(tbl[i].err));
            check($sformatf("row%0d gnt_to", i), 32'(gnt_to), 32'h0);
        end

        // ---- Unacknowledged grant to ch1 (ch2 also requesting) ----
        reqep = 4'h6; drvn = 4'h0;
        step();
        check("hold grant trn", 32'(trn), 32'h2);
        check("hold grant id", 32'(grant_id), 32'h1);
`ifdef CHN_ARB_GNT_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("tmo wait%0d trn", i), 32'(trn), 32'h2);
            check($sformatf("tmo wait%0d gnt_to", i), 32'(gnt_to), 32'h0);
        end
        step();
        check("tmo fire trn", 32'(trn), 32'h0);
        check("tmo fire grant_vld", 32'(grant_vld), 32'h0);
        check("tmo fire gnt_to", 32'(gnt_to), 32'h1);
        step();
        check("tmo gap gnt_to", 32'(gnt_to), 32'h0);
        check("tmo gap trn", 32'(trn), 32'h0);
        step();
        check("tmo next trn", 32'(trn), 32'h4);
        check("tmo next id", 32'(grant_id), 32'h2);
`else
        for (int i = 1; i <= 1000; i++) begin
            step();
            check($sformatf("hold%0d trn", i), 32'(trn), 32'h2);
            check($sformatf("hold%0d gnt_to", i), 32'(gnt_to), 32'h0);
        end
        reqep = 4'h4;
        step();
        check("hold abort trn", 32'(trn), 32'h0);
        check("hold abort grant_vld", 32'(grant_vld), 32'h0);
        step();
        step();
        check("hold next trn", 32'(trn), 32'h4);
        check("hold next id", 32'(grant_id), 32'h2);
`endif
        reqep = 4'h0;

        // ---- NUM_CHN=1: channel 0 granted every round ----
        req1 = 1'b1;
        step();
        check("one grant1 trn", 32'(trn1), 32'h1);
        check("one grant1 id", 32'(id1), 32'h0);
        drv1 = 1'b1;
        step();
        check("one busy trn", 32'(trn1), 32'h0);
        check("one busy vld", 32'(vld1), 32'h1);
        drv1 = 1'b0;
        step();
        step();
        check("one arb trn", 32'(trn1), 32'h0);
        step();
        check("one grant2 trn", 32'(trn1), 32'h1);
        check("one grant2 vld", 32'(vld1), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/chn_arb_rr.md
Name: chn_arb_rr

Overview:
Parametrised round-robin arbiter granting exclusive access to the PCIe endpoint TX interface among NUM_CHN requesters, such as DMA channels and the register interface.
- Issues a one-hot grant and holds it until the winner acknowledges by driving the endpoint.
- Waits for the winner's release, then inserts one turnaround cycle before re-arbitrating.
- Sits between channel TX engines and the endpoint TX mux; grant_id drives the mux select.

Parameters:
NUM_CHN, 4, number of requesting channels (1..16).
CHN_W, 2, width of grant_id; must be ≥ ceil(log2(NUM_CHN)), minimum 1.
TIMEOUT_CYC, 1024, grant-acknowledge timeout in clk cycles (used only with optional feature; ≥ 2).

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
reqep  in  NUM_CHN  per-channel request for the endpoint; level, held until served or withdrawn.
drvn  in  NUM_CHN  per-channel "currently driving endpoint" flag.
trn  out  NUM_CHN  one-hot grant (turn) to channel.
grant_id  out  CHN_W  index of the most recently granted channel.
grant_vld  out  1  high while a channel holds a grant or is driving (states GNT and BUSY).
err_drv  out  1  sticky: a drvn bit was seen high on a channel without ownership.
gnt_to  out  1  one-cycle pulse on grant timeout (optional feature only; tied 0 otherwise).

Behaviour:
Reset values: trn=0, grant_id=0, grant_vld=0, err_drv=0, gnt_to=0, ptr=NUM_CHN-1 (so channel 0 wins first), state=INIT.

FSM, all outputs registered:
- INIT: trn=0; next state ARB.
- ARB:
  - If any drvn bit is high, hold in ARB and issue no grant (stale driver guard).
  - Else if reqep≠0: winner w = first set bit searching from ptr+1 upward, wrapping NUM_CHN-1→0. Set trn[w]=1, grant_id=w, grant_vld=1, ptr=w; go to GNT.
  - Else stay in ARB.
- GNT:
  - If drvn[w]: trn=0, go to BUSY.
  - Else if !reqep[w]: abort; trn=0, grant_vld=0, go to GAP. ptr keeps w, so the channel loses its turn.
  - Else hold.
- BUSY: trn=0, grant_vld=1. When drvn[w]=0: grant_vld=0, go to GAP.
- GAP: one idle cycle (endpoint turnaround), then ARB.

Latency: reqep high while in ARB with drvn=0 at edge n → trn high after edge n. Minimum back-to-back period is 4 cycles (ARB, GNT, BUSY, GAP) with a 1-cycle drive.

Fairness: a channel requesting continuously is granted at most once per NUM_CHN grants while others request.

Error detection: any drvn[i] high, i≠w, in GNT or BUSY sets err_drv. err_drv clears only on rst; the FSM ignores the offending channel.

Boundary conditions:
- NUM_CHN=1: ptr wraps to 0, so channel 0 is granted every round.
- reqep and drvn asserted in the same cycle are both sampled at that edge; drvn is checked first in GNT.
- rst mid-operation: within one cycle, trn=0 and the FSM returns to INIT.

Optional Feature:
Macro CHN_ARB_GNT_TIMEOUT_EN.
- With it: a counter starts on entry to GNT. If drvn[w] stays low for TIMEOUT_CYC consecutive GNT cycles, then trn=0, grant_vld=0, gnt_to pulses for 1 cycle, and the FSM goes to GAP. The counter clears on leaving GNT.
- Without it: GNT waits indefinitely (only drvn or reqep withdrawal exits), no counter is built, and gnt_to is tied 0.

Test Plan:
- Reset, NUM_CHN=4, reqep=4'b1111, each granted channel drives 3 cycles → grants in order 0,1,2,3,0; grant_id matches; exactly one GAP cycle between BUSY exit and next ARB.
- reqep=4'b0100 only, pulsed each round → channel 2 granted every round; trn=4'b0100 one cycle after ARB; err_drv stays 0.
- Grant to ch1, drop reqep[1] before drvn → trn falls next cycle, FSM returns via GAP, next grant goes to ch2 if it is requesting.
- During BUSY on ch0, assert drvn[3] one cycle → err_drv=1 and stays 1; ch0 release still proceeds to GAP/ARB; rst clears err_drv.
- Assert rst while BUSY on ch2 → trn=0, grant_vld=0 next cycle; after release the first grant goes to ch0.
- With CHN_ARB_GNT_TIMEOUT_EN, TIMEOUT_CYC=8, grant ch1 and never drive → trn drops after 8 GNT cycles, gnt_to pulses once, next grant ch2; without the macro, trn stays high for 1000 cycles.
